// File: rtl/apb_ctrl_pkg.sv
// Shared types and defaults for the APB request arbiter.
// Holds the FSM state encoding and the index-width helper.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// The search starts just after last_grant, so the requester served most recently has the lowest priority.
module rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] w_idx;

  // Walk from the farthest slot to the nearest one; the last hit is the highest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_idx     = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master that shares one completer between NUM_REQ requesters.
// It runs SETUP/ACCESS with an ACCESS-phase timeout and returns one-cycle responses.
module apb_req_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e          r_state, w_state_next;
  logic [IDX_W-1:0]    r_last_grant, r_gnt_idx, w_gnt_idx;
  logic [NUM_REQ-1:0]  w_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_done, w_abort;
  logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_gnt_idx)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // pready on the final allowed cycle wins over the timeout.
  always_comb begin
    w_state_next = r_state;
    w_done       = (r_state == ACCESS) && pready;
    w_abort      = (r_state == ACCESS) && !pready && (r_cnt == CNT_W'(TIMEOUT - 1));
    case (r_state)
      IDLE:    if (|req_valid) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (w_done || w_abort) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_gnt_idx    <= '0;
      r_cnt        <= '0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_gnt_idx    <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_pwrite     <= req_write[w_gnt_idx];
            r_paddr      <= w_addr_arr[w_gnt_idx];
            r_pwdata     <= w_wdata_arr[w_gnt_idx];
          end
        end
        SETUP: r_cnt <= '0;
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= 1'b0;
          end else if (w_abort) begin
            r_rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign busy      = (r_state != IDLE);
  assign psel      = (r_state != IDLE);
  assign penable   = (r_state == ACCESS);
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter with a behavioural APB completer.
// Expected responses are queued at acceptance and compared when rsp_valid pulses.
module tb_apb_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset;
  logic [NR-1:0] req_valid, req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [DW-1:0] rsp_rdata, prdata, pwdata;
  logic          rsp_err, busy, psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;

  apb_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int            g;
    logic [AW-1:0] addr;
    bit            wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit            err;
    int            acc;
    int            wt;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            tb_last = NR - 1;
  int            acc_n = 0;
  int            pen_cnt = 0;
  int            req_wt[NR];
  logic [DW-1:0] cmp_mem[256];
  logic [DW-1:0] ref_mem[256];

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (last + k) % NR;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  // Scoreboard, grant model and completer model, all evaluated away from the active edge.
  always @(negedge pclk) begin
    exp_t e;
    int   g;
    if (!preset) begin
      if (|rsp_valid) begin
        if (q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("rsp_onehot", 32'(rsp_valid), 32'(1 << e.g));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("latency", 32'(cyc - e.acc), 32'(e.err ? (2 + TO) : (3 + e.wt)));
          check("penable_cycles", 32'(pen_cnt), 32'(e.err ? TO : (e.wt + 1)));
          $display("txn req%0d %s addr=0x%02h rdata=0x%08h err=%0d", e.g, e.wr ? "WR" : "RD",
                   e.addr, rsp_rdata, rsp_err);
        end
      end
      if (|(req_valid & req_ready)) begin
        g = rr_pick(req_valid, tb_last);
        check("grant", 32'(req_ready), 32'(1 << g));
        tb_last = g;
        e.g     = g;
        e.wt    = req_wt[g];
        e.err   = (e.wt >= TO);
        e.wr    = req_write[g];
        e.addr  = req_addr[g*AW +: AW];
        e.wdata = req_wdata[g*DW +: DW];
        e.rdata = (e.wr || e.err) ? '0 : ref_mem[e.addr];
        if (e.wr && !e.err) ref_mem[e.addr] = e.wdata;
        e.acc   = cyc;
        q.push_back(e);
      end
      if (psel && !penable) begin
        pen_cnt = 0;
        acc_n   = 0;
        if (q.size() > 0) begin
          check("setup_paddr", 32'(paddr), 32'(q[0].addr));
          check("setup_pwrite", 32'(pwrite), 32'(q[0].wr));
          if (q[0].wr) check("setup_pwdata", pwdata, q[0].wdata);
        end
      end
      if (psel && penable) begin
        pen_cnt++;
        if (q.size() > 0) begin
          check("paddr_hold", 32'(paddr), 32'(q[0].addr));
          pready = (acc_n == q[0].wt);
        end else begin
          pready = 1'b1;
        end
        prdata = cmp_mem[paddr];
        if (pready && pwrite) cmp_mem[paddr] = pwdata;
        acc_n++;
      end else begin
        pready = 1'b0;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that follows acceptance.
  task automatic issue(input int r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int wt);
    int n;
    n = 0;
    req_wt[r]             = wt;
    req_write[r]          = w;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r]          = 1'b1;
    forever begin
      @(negedge pclk);
      if (req_ready[r]) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge pclk); #1;
    req_valid[r] = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      cmp_mem[i] = {4{b}} ^ 32'h5A5A_0000;
      ref_mem[i] = {4{b}} ^ 32'h5A5A_0000;
    end
    preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    for (int i = 0; i < NR; i++) req_wt[i] = 0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_paddr", 32'(paddr), 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    @(posedge pclk); #1;
    preset = 1'b0;

    // Single write then read back.
    issue(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 0);
    issue(0, 1'b0, 8'h04, 32'h0, 0);
    // Read with three wait states.
    issue(1, 1'b0, 8'h04, 32'h0, 3);
    // Two requesters contending continuously.
    fork
      begin
        issue(0, 1'b1, 8'h00, 32'h1111_0000, 0);
        issue(0, 1'b1, 8'h00, 32'h2222_0000, 0);
      end
      begin
        issue(1, 1'b1, 8'h08, 32'h3333_0008, 0);
        issue(1, 1'b1, 8'h08, 32'h4444_0008, 0);
      end
    join
    // Stuck completer followed by a pending request.
    fork
      issue(0, 1'b0, 8'h04, 32'h0, 1000);
      issue(1, 1'b0, 8'h08, 32'h0, 0);
    join
    // pready arriving on the last allowed ACCESS cycle.
    issue(0, 1'b0, 8'h08, 32'h0, TO - 1);
    issue(1, 1'b0, 8'h00, 32'h0, 0);

    // Reset while an access is outstanding.
    issue(0, 1'b0, 8'h10, 32'h0, 1000);
    repeat (5) @(negedge pclk);
    check("pre_rst_penable", 32'(penable), 32'd1);
    #2;
    preset = 1'b1;
    #1;
    check("midrst_psel", 32'(psel), 32'd0);
    check("midrst_penable", 32'(penable), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    q.delete();
    tb_last = NR - 1;
    pready  = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    repeat (4) @(posedge pclk);
    #1;
    fork
      issue(1, 1'b0, 8'h00, 32'h0, 0);
      issue(0, 1'b0, 8'h04, 32'h0, 0);
    join

    for (int k = 0; k < 100 && q.size() > 0; k++) @(posedge pclk);
    @(negedge pclk);
    check("drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
